key_expand192_seq: RTL and testbench
====================================

Name: key_expand192_seq

Overview:
Sequential AES-192 key-expansion engine. It loads a 192-bit cipher key and generates the 52 schedule words w0..w51, one word per cycle. Words are packed into thirteen 128-bit round keys, rk0..rk12, delivered over a valid/ready stream. The block sits directly upstream of the round datapath. It drives the existing rcon module, with its sel input fed from the internal group counter and its outs output XORed into the temp word.

Parameters:
None. AES-192 constants (Nk=6, Nr=12, 52 words) are fixed and taken from the shared package.

Ports:
clk       input   1    clock, rising-edge
rst_n     input   1    asynchronous active-low reset
start     input   1    begin expansion; sampled only in IDLE
key       input   192  cipher key; key[191:160]=w0 ... key[31:0]=w5; sampled on accepted start
busy      output  1    high from the cycle after accepted start until done
rk_valid  output  1    rk/rk_idx hold a valid round key
rk_ready  input   1    consumer accepts the round key when rk_valid && rk_ready
rk_idx    output  4    round-key number, 0..12
rk        output  128  round key; rk[127:96]=w(4*rk_idx)
done      output  1    one-cycle pulse after rk12 handshake

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, rk_valid=0, done=0, rk=0, rk_idx=0; window, counters and accumulator cleared. Reset mid-expansion aborts with no further outputs.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: start=1 loads the 6-word window from key and sets word index i=0, then moves to RUN. start=0 stays IDLE.
- start outside IDLE is ignored; key is not resampled.
- RUN, advance condition: one word w[i] enters the 4-word accumulator per cycle, unless stalled.
  - For i<6: w[i] is the key word.
  - For i>=6: w[i] = w[i-6] ^ temp.
  - temp = SubWord(RotWord(w[i-1])) ^ rcon.outs when i mod 6 == 0; otherwise temp = w[i-1].
  - rcon sel = i/6 (1..8). sel stays 0 (outs=0) when not at a group boundary.
- Window: 6-entry shift register; the new word shifts in and the oldest shifts out. A mod-6 phase counter and a 4-bit group counter are used; no divider.
- Packing: when the 4th word of a group enters, rk is registered, rk_idx=i/4, and rk_valid=1 from the next cycle.
- Stall: rk_valid && !rk_ready freezes i, window, phase and accumulator. rk, rk_idx and rk_valid hold stable.
  - rk_valid && rk_ready in the same cycle as a 4th-word entry: the new rk replaces the old one and rk_valid stays 1.
  - rk_valid && rk_ready with no new rk: rk_valid drops next cycle.
- Latency with rk_ready held high, start accepted at cycle T:
  - w[i] enters at T+1+i.
  - rk_n visible at T+5+4n.
  - rk12 visible at T+53; handshake at T+53.
  - done=1 and busy=0 at T+54 (state DONE, one cycle), then IDLE. A start in that DONE cycle is ignored.
- i runs 0..51 and never wraps; after w51 generation halts until rk12 is accepted.

Decomposition:
- Shared package aes192_pkg:
  - NK=6, NR=12, NWORDS=52.
  - Word typedef (logic [31:0]) and round-key typedef (logic [127:0]).
  - FSM state enum {IDLE, RUN, DONE}.
  - RotWord as a function.
- Sub-module sub_word: four combinational S-boxes, 32-bit in/out.
- Instantiate the existing rcon as-is.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, rk_ready=1:
  - rk0 = 8e73b0f7da0e6452c810f32b809079e5.
  - w6 = fe0c91f7 appears as rk1[63:32].
  - rk12 = e98ba06f448c773c8ecc720401002202.
  - done pulses exactly at T+54.
- All-zero key, rk_ready=1 -> rk0=0; rk1 = 00000000_00000000_62636363_62636363; 13 handshakes, rk_idx 0..12 in order.
- A.2 key with rk_ready pseudo-random (≈50%) -> round-key sequence identical to the first test; rk/rk_idx never change while rk_valid && !rk_ready; done follows the rk12 handshake by 1 cycle.
- start pulsed again at T+10 with a different key -> ignored; outputs still match the first key; busy stays high.
- rst_n=0 asynchronously at T+20, released, then a new start with the zero key -> rk_valid/busy drop immediately on reset; the fresh run matches the zero-key expectations with no residue.
- rk_ready=0 from T+1 for 30 cycles -> rk_valid=1 with rk_idx=0 held for the whole window; no rk_idx skipped after release.

Source files
------------

// File: rtl/aes192_pkg.sv
// Shared AES-192 constants, word/round-key types, key-expansion FSM states
// and the RotWord helper.
package aes192_pkg;
    localparam int NK     = 6;
    localparam int NR     = 12;
    localparam int NWORDS = 52;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/key_expand192_seq_sub_word.sv
// SubWord: four combinational AES S-boxes, computed as GF(2^8) inverse
// followed by the affine transform.
module sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] b;
        r = x;
        for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), x);
        b = gf_mul(r, r);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign o_word[8*g +: 8] = sbox(i_word[8*g +: 8]);
    end
endmodule

// File: rtl/rcon.sv
// AES round constant lookup: sel 1..10 gives rcon in the top byte, else zero.
module rcon (
    input  logic [3:0]  sel,
    output logic [31:0] outs
);
    logic [7:0] w_byte;

    always_comb begin
        w_byte = 8'h00;
        case (sel)
            4'd1:    w_byte = 8'h01;
            4'd2:    w_byte = 8'h02;
            4'd3:    w_byte = 8'h04;
            4'd4:    w_byte = 8'h08;
            4'd5:    w_byte = 8'h10;
            4'd6:    w_byte = 8'h20;
            4'd7:    w_byte = 8'h40;
            4'd8:    w_byte = 8'h80;
            4'd9:    w_byte = 8'h1b;
            4'd10:   w_byte = 8'h36;
            default: w_byte = 8'h00;
        endcase
    end

    assign outs = {w_byte, 24'h000000};
endmodule

// File: rtl/key_expand192_seq.sv
// Sequential AES-192 key expansion: one schedule word per cycle, packed into
// 13 round keys on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; window loaded from key on accept
// RUN   | generating w0..w51 and streaming rk0..rk12
// DONE  | one-cycle done pulse after rk12 is accepted
module key_expand192_seq
    import aes192_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] key,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk,
    output logic         done
);
    state_t     r_state, w_state_nxt;
    word_t      r_win [NK];
    word_t      r_acc [3];
    logic [2:0] r_phase;
    logic [3:0] r_grp;
    logic [5:0] r_idx;
    logic [1:0] r_pos;
    logic [3:0] r_rk_cnt;
    rkey_t      r_rk;
    logic [3:0] r_rk_idx;
    logic       r_rk_valid;

    logic       w_gen_done, w_stall, w_adv, w_boundary;
    logic [3:0] w_sel;
    word_t      w_rot, w_sub, w_rcon, w_temp, w_key_word, w_new;

    assign w_gen_done = (r_idx == 6'(NWORDS));
    assign w_stall    = r_rk_valid && !rk_ready;
    assign w_adv      = (r_state == RUN) && !w_gen_done && !w_stall;
    assign w_boundary = (r_phase == 3'd0) && (r_grp != 4'd0);
    assign w_sel      = w_boundary ? r_grp : 4'd0;
    assign w_rot      = rot_word(r_win[NK-1]);

    sub_word u_sub_word (.i_word(w_rot), .o_word(w_sub));
    rcon     u_rcon     (.sel(w_sel), .outs(w_rcon));

    assign w_temp = w_boundary ? (w_sub ^ w_rcon) : r_win[NK-1];

    // group 0 replays the loaded key words without shifting the window
    always_comb begin
        w_key_word = r_win[0];
        case (r_phase)
            3'd1:    w_key_word = r_win[1];
            3'd2:    w_key_word = r_win[2];
            3'd3:    w_key_word = r_win[3];
            3'd4:    w_key_word = r_win[4];
            3'd5:    w_key_word = r_win[5];
            default: w_key_word = r_win[0];
        endcase
    end

    assign w_new = (r_grp == 4'd0) ? w_key_word : (r_win[0] ^ w_temp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_gen_done && r_rk_valid && rk_ready) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) r_win[k] <= '0;
            for (int k = 0; k < 3; k++)  r_acc[k] <= '0;
            r_phase    <= '0;
            r_grp      <= '0;
            r_idx      <= '0;
            r_pos      <= '0;
            r_rk_cnt   <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                for (int k = 0; k < NK; k++) r_win[k] <= key[191 - 32*k -: 32];
                r_phase  <= '0;
                r_grp    <= '0;
                r_idx    <= '0;
                r_pos    <= '0;
                r_rk_cnt <= '0;
            end else if (w_adv) begin
                r_idx   <= r_idx + 6'd1;
                r_phase <= (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
                if (r_phase == 3'd5) r_grp <= r_grp + 4'd1;
                if (r_grp != 4'd0) begin
                    for (int k = 0; k < NK-1; k++) r_win[k] <= r_win[k+1];
                    r_win[NK-1] <= w_new;
                end
                r_pos <= r_pos + 2'd1;
                case (r_pos)
                    2'd0: r_acc[0] <= w_new;
                    2'd1: r_acc[1] <= w_new;
                    2'd2: r_acc[2] <= w_new;
                    default: begin
                        r_rk     <= {r_acc[0], r_acc[1], r_acc[2], w_new};
                        r_rk_idx <= r_rk_cnt;
                        r_rk_cnt <= r_rk_cnt + 4'd1;
                    end
                endcase
            end

            if (w_adv && r_pos == 2'd3) r_rk_valid <= 1'b1;
            else if (r_rk_valid && rk_ready) r_rk_valid <= 1'b0;
        end
    end

    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk       = r_rk;
endmodule

// File: tb/tb_key_expand192_seq.sv
// Bench for key_expand192_seq: reference key schedule built from a brute-force
// S-box table, checked over several ready patterns, restart and reset cases.
module tb_key_expand192_seq;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [191:0] key;
    logic         busy, rk_valid, rk_ready, done;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [13];
    logic [127:0] got_rk [13];

    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    key_expand192_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk(rk), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 0;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8]
                       ^ inv[(b+7)%8] ^ c[b];
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic build_model(input logic [191:0] k);
        logic [31:0] w [52];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-6] ^ t;
        end
        for (int r = 0; r < 13; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for cycles 1..30
    task automatic run_exp(input logic [191:0] k, input int mode, input int restart_at,
                           input int reset_at);
        int cyc, n_hs, hs_last, done_cyc, done_cnt, stall_err, busy_err, hold_err;
        bit fin;
        logic p_valid, p_ready;
        logic [127:0] p_rk;
        logic [3:0] p_idx;
        build_model(k);
        n_hs = 0; hs_last = -1; done_cyc = -1; done_cnt = 0;
        stall_err = 0; busy_err = 0; hold_err = 0; fin = 0;
        p_valid = 0; p_ready = 0; p_rk = 0; p_idx = 0;
        @(posedge clk); #1;
        start = 1; key = k; rk_ready = (mode == 0);
        @(posedge clk); #1;
        start = 0; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cyc = 1;
        while (cyc < 400 && !fin) begin
            start = (cyc == restart_at);
            if (cyc == restart_at) key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (cyc == reset_at) begin
                rst_n = 0;
                #1;
                chk("rst_rk_valid", rk_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rk", rk, 0);
                chk("rst_rk_idx", rk_idx, 0);
                start = 0;
                @(posedge clk); #1;
                rst_n = 1;
                return;
            end
            if (p_valid && !p_ready && (!rk_valid || rk !== p_rk || rk_idx !== p_idx))
                stall_err++;
            if (done_cyc < 0 && !done && !busy) busy_err++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk("busy_at_done", busy, 0);
                end
            end
            case (mode)
                0:       rk_ready = 1;
                1:       rk_ready = 1'($urandom_range(0, 1));
                default: rk_ready = (cyc > 30);
            endcase
            if (mode == 2 && cyc >= 5 && cyc <= 30 && (!rk_valid || rk_idx !== 4'd0)) hold_err++;
            if (rk_valid && rk_ready) begin
                if (n_hs < 13) begin
                    chk("rk", rk, exp_rk[n_hs]);
                    chk("rk_idx", rk_idx, n_hs);
                    got_rk[n_hs] = rk;
                end
                if (mode == 0) chk("rk_time", cyc, 5 + 4*n_hs);
                hs_last = cyc;
                n_hs++;
            end
            p_valid = rk_valid; p_ready = rk_ready; p_rk = rk; p_idx = rk_idx;
            if (done_cyc >= 0 && cyc == done_cyc + 2) fin = 1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 0;
        chk("timeout", fin, 1);
        chk("hs_count", n_hs, 13);
        chk("done_after_hs", done_cyc, hs_last + 1);
        chk("done_pulses", done_cnt, 1);
        if (mode == 0) chk("done_time", done_cyc, 54);
        chk("stall_hold", stall_err, 0);
        chk("busy_run", busy_err, 0);
        if (mode == 2) chk("ready_low_hold", hold_err, 0);
    endtask

    initial begin
        rst_n = 0; start = 0; key = 0; rk_ready = 0;
        build_sbox();
        #23;
        chk("reset_busy", busy, 0);
        chk("reset_valid", rk_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_rk", rk, 0);
        chk("reset_idx", rk_idx, 0);
        rst_n = 1;

        run_exp(KEY_A2, 0, -1, -1);
        chk("a2_rk0", got_rk[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
        chk("a2_w6", got_rk[1][63:32], 32'hfe0c91f7);
        chk("a2_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

        run_exp(192'h0, 0, -1, -1);
        chk("zero_rk0", got_rk[0], 128'h0);
        chk("zero_rk1", got_rk[1], 128'h00000000_00000000_62636363_62636363);

        run_exp(KEY_A2, 1, -1, -1);
        run_exp(KEY_A2, 0, 10, -1);
        run_exp(KEY_A2, 0, -1, 20);
        run_exp(192'h0, 0, -1, -1);
        chk("post_rst_rk1", got_rk[1], 128'h00000000_00000000_62636363_62636363);
        run_exp(KEY_A2, 2, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
